mcycle_ctrl: RTL and testbench

Multi-cycle control FSM for the single-cycle-datapath SCPU core, converted to multi-cycle operation. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives the ALU operation code and the PC, IR and register-file write enables, and handshakes with instruction and data memories that may stall. It sits beside the datapath in `core/scpu` and replaces the per-instruction combinational control.

---
 rtl/scpu_pkg.sv | 37 +++
 rtl/mcycle_ctrl_if.sv | 13 +
 rtl/alu_op_dec.sv | 30 +++
 rtl/mcycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_mcycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scpu_pkg.sv
// Shared SCPU definitions: opcodes, ALU operation codes, control FSM states
// and write-back source select codes.
package scpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_LUI) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Instruction/data memory handshake between the control FSM and the memories.
interface mcycle_ctrl_if;
    logic imem_req;
    logic imem_rdata_vld;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (output imem_req, dmem_req, dmem_we,
                    input  imem_rdata_vld, dmem_ready);
    modport slave  (input  imem_req, dmem_req, dmem_we,
                    output imem_rdata_vld, dmem_ready);
endinterface

// File: rtl/alu_op_dec.sv
// Combinational instruction -> ALU operation decode. inst[30] selects the
// alternate op only where the ISA defines one (sub, sra, srai).
module alu_op_dec
    import scpu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  alu_op
);
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_b30;
    logic       w_unused_bits;

    assign w_opcode      = inst[6:0];
    assign w_funct3      = inst[14:12];
    assign w_b30         = inst[30];
    assign w_unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        alu_op = ALU_ADD;
        case (w_opcode)
            OP_R:      alu_op = (w_funct3 == 3'b000 || w_funct3 == 3'b101) ?
                                {w_b30, w_funct3} : {1'b0, w_funct3};
            // I-type immediates overlap bit 30, so only the shift keeps it
            OP_I:      alu_op = (w_funct3 == 3'b101) ? {w_b30, 3'b101} : {1'b0, w_funct3};
            OP_BRANCH: alu_op = ALU_SUB;
            default:   alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle SCPU control: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], one
// instruction at a time, with stall-tolerant memory handshakes.
module mcycle_ctrl
    import scpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    mcycle_ctrl_if.master      mem,
    input  logic [31:0]        inst,
    input  logic               alu_zero,
    input  logic               cmp_lt,
    input  logic               cmp_ltu,
    output logic               ir_we,
    output logic               pc_we,
    output logic               rf_we,
    output logic               pc_sel,
    output logic               alu_src_b,
    output logic [1:0]         wb_sel,
    output logic [3:0]         alu_op,
    output logic [31:0]        pc_rst_val,
    output logic               halted,
    output logic [31:0]        instret
);
    state_t      r_state, w_next;
    logic [31:0] r_instret;
    logic [3:0]  w_dec_op;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load, w_is_store, w_is_branch, w_is_jal;
    logic        w_br_taken, w_br_bad, w_retire;

    alu_op_dec u_alu_op_dec (.inst(inst), .alu_op(w_dec_op));

    assign w_opcode    = inst[6:0];
    assign w_funct3    = inst[14:12];
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_br_bad    = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = alu_zero;
            3'b001:  w_br_taken = !alu_zero;
            3'b100:  w_br_taken = cmp_lt;
            3'b101:  w_br_taken = !cmp_lt;
            3'b110:  w_br_taken = cmp_ltu;
            3'b111:  w_br_taken = !cmp_ltu;
            default: w_br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  if (mem.imem_rdata_vld) w_next = S_DECODE;
            S_DECODE: w_next = op_legal(w_opcode) ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_branch) begin
                    if (w_br_bad) w_next = S_HALT;
                    else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_is_load || w_is_store) w_next = S_MEM;
                else                                  w_next = S_WB;
            end
            S_MEM: begin
                if (mem.dmem_ready) begin
                    w_next   = w_is_store ? S_FETCH : S_WB;
                    w_retire = w_is_store;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        pc_sel       = 1'b0;
        alu_src_b    = 1'b0;
        wb_sel       = WB_ALU;
        alu_op       = ALU_ADD;
        halted       = 1'b0;
        case (r_state)
            S_FETCH: begin
                // held-reset cycles must not start a fetch
                if (!rst) begin
                    mem.imem_req = 1'b1;
                    if (mem.imem_rdata_vld) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
            end
            S_DECODE: alu_op = w_dec_op;
            S_EXEC: begin
                alu_op    = w_dec_op;
                alu_src_b = w_is_load || w_is_store;
                if ((w_is_branch && !w_br_bad && w_br_taken) || w_is_jal) begin
                    pc_we  = 1'b1;
                    pc_sel = 1'b1;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = w_is_store;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = w_is_load ? WB_LOAD : (w_is_jal ? WB_PC4 : WB_ALU);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign instret    = r_instret;
    assign pc_rst_val = RESET_PC;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: directed vector table, hand-written
// reset/halt sequences and random instructions against an instruction-level model.
module tb_mcycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = '0;
    logic        alu_zero = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
    logic        ir_we, pc_we, rf_we, pc_sel, alu_src_b, halted;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [31:0] pc_rst_val, instret;

    mcycle_ctrl_if mif();

    mcycle_ctrl #(.RESET_PC(32'h0000_1000)) dut (
        .clk(clk), .rst(rst), .mem(mif), .inst(inst),
        .alu_zero(alu_zero), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel),
        .alu_src_b(alu_src_b), .wb_sel(wb_sel), .alu_op(alu_op),
        .pc_rst_val(pc_rst_val), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] aop;
        bit         ret;
        bit         halt;
        int         tgt;
        int         rf;
        logic [1:0] wsel;
        int         dreq;
        bit         dwe;
        int         srcb;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        int          iw;
        int          dw;
        bit          z, lt, ltu;
        exp_t        e;
    } vec_t;

    typedef struct {
        int         cyc, dreq, rf, tgt, npc, nir, fok, srcb, stray;
        logic [3:0] aop_d, aop_e;
        logic [1:0] wsel;
        bit         dwe, halt, tmo;
    } obs_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret = 0;
    vec_t        tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Instruction-level reference: cycle count and side effects from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input int iw, input int dw,
                                   input bit z, input bit lt, input bit ltu);
        exp_t       e;
        logic [6:0] op   = ins[6:0];
        logic [2:0] f    = ins[14:12];
        bit         b30  = ins[30];
        int         fc   = iw + 1;
        bit         cond;
        e = '{default: 0};
        case (op)
            7'b0110011: begin
                e.aop = (f == 3'd0 || f == 3'd5) ? {b30, f} : {1'b0, f};
                e.cyc = fc + 3; e.ret = 1; e.rf = 1;
            end
            7'b0010011: begin
                e.aop = (f == 3'd5) ? {b30, f} : {1'b0, f};
                e.cyc = fc + 3; e.ret = 1; e.rf = 1;
            end
            7'b0110111: begin e.cyc = fc + 3; e.ret = 1; e.rf = 1; end
            7'b1101111: begin e.cyc = fc + 3; e.ret = 1; e.rf = 1; e.tgt = 1; e.wsel = 2'b10; end
            7'b0000011: begin
                e.cyc = fc + 2 + (dw + 1) + 1; e.ret = 1; e.rf = 1; e.wsel = 2'b01;
                e.dreq = dw + 1; e.srcb = 1;
            end
            7'b0100011: begin
                e.cyc = fc + 2 + (dw + 1); e.ret = 1; e.dreq = dw + 1; e.dwe = 1; e.srcb = 1;
            end
            7'b1100011: begin
                e.aop = 4'b1000;
                if (f == 3'd2 || f == 3'd3) begin
                    e.halt = 1; e.cyc = fc + 2;
                end else begin
                    cond  = f[2] ? (f[1] ? ltu : lt) : z;
                    e.tgt = int'(cond ^ f[0]);
                    e.cyc = fc + 2; e.ret = 1;
                end
            end
            default: begin e.halt = 1; e.cyc = fc + 1; end
        endcase
        return e;
    endfunction

    // Starts just after a negedge with the DUT in FETCH; returns in the cycle
    // where the next fetch begins or the FSM halts.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input bit z, input bit lt, input bit ltu, output obs_t o);
        int ni = 0, nd = 0;
        o = '{default: 0};
        o.aop_d = 4'hf; o.aop_e = 4'hf;
        inst = ins; alu_zero = z; cmp_lt = lt; cmp_ltu = ltu;
        for (int k = 0; k < 64; k++) begin
            mif.imem_rdata_vld = 1'b0; mif.dmem_ready = 1'b0;
            #1;
            if (halted) begin o.halt = 1; o.cyc = k; return; end
            if (k > iw && mif.imem_req) begin o.cyc = k; return; end
            if (mif.imem_req) begin mif.imem_rdata_vld = (ni == iw); ni++; end
            if (mif.dmem_req) begin mif.dmem_ready = (nd == dw); nd++; o.dreq++; end
            #1;
            if (ir_we) o.nir++;
            if (pc_we) o.npc++;
            if (pc_we && pc_sel) o.tgt++;
            if (ir_we && pc_we && !pc_sel) o.fok++;
            if (rf_we) begin o.rf++; o.wsel = wb_sel; end
            if (mif.dmem_we) o.dwe = 1;
            if (alu_src_b) o.srcb++;
            if (k == iw + 1)      o.aop_d = alu_op;
            else if (k == iw + 2) o.aop_e = alu_op;
            else if (alu_op != 4'd0) o.stray++;
            @(negedge clk);
        end
        o.tmo = 1;
        mif.imem_rdata_vld = 1'b0; mif.dmem_ready = 1'b0;
    endtask

    task automatic cmp(input string nm, input obs_t o, input exp_t e, input int iw);
        chk({nm, ".timeout"}, 32'(o.tmo), 0);
        chk({nm, ".cycles"}, o.cyc, e.cyc);
        chk({nm, ".halt"}, 32'(o.halt), 32'(e.halt));
        chk({nm, ".alu_op_dec"}, 32'(o.aop_d), 32'(e.aop));
        if (!(e.halt && e.cyc == iw + 2)) chk({nm, ".alu_op_exec"}, 32'(o.aop_e), 32'(e.aop));
        chk({nm, ".alu_op_idle"}, o.stray, 0);
        chk({nm, ".fetch_we"}, o.fok, 1);
        chk({nm, ".ir_we"}, o.nir, 1);
        chk({nm, ".pc_we"}, o.npc, 1 + e.tgt);
        chk({nm, ".target"}, o.tgt, e.tgt);
        chk({nm, ".rf_we"}, o.rf, e.rf);
        chk({nm, ".wb_sel"}, 32'(o.wsel), 32'(e.wsel));
        chk({nm, ".dmem_req"}, o.dreq, e.dreq);
        chk({nm, ".dmem_we"}, 32'(o.dwe), 32'(e.dwe));
        chk({nm, ".alu_src_b"}, o.srcb, e.srcb);
        if (e.ret) exp_instret = exp_instret + 32'd1;
        chk({nm, ".instret"}, instret, exp_instret);
    endtask

    task automatic do_reset();
        rst = 1'b1; mif.imem_rdata_vld = 1'b0; mif.dmem_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset.outputs", {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_we, pc_we, rf_we,
                              pc_sel, alu_src_b, halted, wb_sel, alu_op}, 0);
        chk("reset.instret", instret, 0);
        chk("reset.pc_rst_val", pc_rst_val, 32'h0000_1000);
        exp_instret = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        obs_t        o;
        exp_t        e;
        logic [31:0] ins;
        int          iw, dw, bad;
        bit          z, lt, ltu;

        mif.imem_rdata_vld = 1'b0; mif.dmem_ready = 1'b0;
        //            inst           iw dw z lt ltu  cyc aop   ret hlt tgt rf wsel  dreq dwe srcb
        tbl[0]  = '{32'h002081B3, 0, 0, 0, 0, 0, '{4, 4'h0, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // add
        tbl[1]  = '{32'h4032D293, 0, 0, 0, 0, 0, '{4, 4'hD, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // srai
        tbl[2]  = '{32'h40208133, 0, 0, 0, 0, 0, '{4, 4'h8, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // sub
        tbl[3]  = '{32'h0032D293, 1, 0, 0, 0, 0, '{5, 4'h5, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // srli, fetch wait
        tbl[4]  = '{32'h4020A1B3, 0, 0, 0, 0, 0, '{4, 4'h2, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // slt, bit30 ignored
        tbl[5]  = '{32'hFFF00093, 0, 0, 0, 0, 0, '{4, 4'h0, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // addi -1
        tbl[6]  = '{32'h00012083, 0, 3, 0, 0, 0, '{8, 4'h0, 1, 0, 0, 1, 2'b01, 4, 0, 1}}; // lw, 3 waits
        tbl[7]  = '{32'h0020A023, 2, 0, 0, 0, 0, '{6, 4'h0, 1, 0, 0, 0, 2'b00, 1, 1, 1}}; // sw
        tbl[8]  = '{32'h00209463, 0, 0, 0, 0, 0, '{3, 4'h8, 1, 0, 1, 0, 2'b00, 0, 0, 0}}; // bne taken
        tbl[9]  = '{32'h00209463, 0, 0, 1, 0, 0, '{3, 4'h8, 1, 0, 0, 0, 2'b00, 0, 0, 0}}; // bne not taken
        tbl[10] = '{32'h0020C463, 0, 0, 0, 1, 0, '{3, 4'h8, 1, 0, 1, 0, 2'b00, 0, 0, 0}}; // blt taken
        tbl[11] = '{32'h0020F463, 0, 0, 0, 0, 1, '{3, 4'h8, 1, 0, 0, 0, 2'b00, 0, 0, 0}}; // bgeu not taken
        tbl[12] = '{32'h0020D463, 0, 0, 0, 0, 0, '{3, 4'h8, 1, 0, 1, 0, 2'b00, 0, 0, 0}}; // bge taken
        tbl[13] = '{32'h000012B7, 0, 0, 0, 0, 0, '{4, 4'h0, 1, 0, 0, 1, 2'b00, 0, 0, 0}}; // lui
        tbl[14] = '{32'h008000EF, 0, 0, 0, 0, 0, '{4, 4'h0, 1, 0, 1, 1, 2'b10, 0, 0, 0}}; // jal
        tbl[15] = '{32'h0000007F, 0, 0, 0, 0, 0, '{2, 4'h0, 0, 1, 0, 0, 2'b00, 0, 0, 0}}; // illegal opcode
        tbl[16] = '{32'h0020A063, 0, 0, 0, 0, 0, '{3, 4'h8, 0, 1, 0, 0, 2'b00, 0, 0, 0}}; // branch funct3 010

        do_reset();

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].iw, tbl[i].dw, tbl[i].z, tbl[i].lt, tbl[i].ltu, o);
            cmp($sformatf("vec%0d", i), o, tbl[i].e, tbl[i].iw);
            if (tbl[i].e.halt) do_reset();
        end

        // HALT is absorbing and ignores fetch handshakes until reset
        run_instr(32'h0000007F, 0, 0, 0, 0, 0, o);
        chk("halt.entered", 32'(o.halt), 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            mif.imem_rdata_vld = 1'($urandom);
            #1;
            if (mif.imem_req || mif.dmem_req || !halted || ir_we || pc_we || rf_we) bad++;
            @(negedge clk);
        end
        mif.imem_rdata_vld = 1'b0;
        chk("halt.absorb", bad, 0);
        do_reset();
        #1;
        chk("halt.rst_fetch", {mif.imem_req, halted}, 2'b10);

        // Reset in the middle of a stalled store
        run_instr(32'h002081B3, 0, 0, 0, 0, 0, o);
        cmp("pre_store_add", o, model(32'h002081B3, 0, 0, 0, 0, 0), 0);
        inst = 32'h0020A023;
        mif.imem_rdata_vld = 1'b1;
        @(negedge clk); mif.imem_rdata_vld = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("midmem.req", {mif.dmem_req, mif.dmem_we}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midmem.req_dropped", 32'(mif.dmem_req), 0);
        chk("midmem.instret", instret, 0);
        exp_instret = 0;
        @(negedge clk);
        rst = 1'b0; mif.dmem_ready = 1'b1;
        #1;
        chk("midmem.late_ready", {mif.imem_req, mif.dmem_req, rf_we}, 3'b100);
        @(negedge clk);
        mif.dmem_ready = 1'b0;
        run_instr(32'h002081B3, 0, 0, 0, 0, 0, o);
        cmp("post_rst_add", o, model(32'h002081B3, 0, 0, 0, 0, 0), 0);

        for (int n = 0; n < 250; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 15))
                0, 1, 13: ins[6:0] = 7'b0110011;
                2, 3, 14: ins[6:0] = 7'b0010011;
                4, 5:     ins[6:0] = 7'b0000011;
                6, 7:     ins[6:0] = 7'b0100011;
                8, 9, 10: ins[6:0] = 7'b1100011;
                11:       ins[6:0] = 7'b0110111;
                12:       ins[6:0] = 7'b1101111;
                default:  ;
            endcase
            iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            z = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
            e = model(ins, iw, dw, z, lt, ltu);
            run_instr(ins, iw, dw, z, lt, ltu, o);
            cmp($sformatf("rnd%0d_%08h", n, ins), o, e, iw);
            if (e.halt || o.halt || o.tmo) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
